regfile_access_arbiter: RTL and testbench
=========================================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares the single-write/single-read 32x32 register-file storage between two requesters.
//  Port 0 is the RIFFA RX/TX channel logic (host-side register access); port 1 is user logic.
//  Arbitrates round-robin, sequences one access at a time and returns read data with a response strobe.
//  Drives the storage write port directly and its combinational read port through rd_addr/rd_data.
// PARAMETERS
//  NUM_REGS     32  number of storage entries; a valid index is 0..NUM_REGS-1
//  DATA_W       32  data width
//  RD_ADDR_OFS  6   offset the storage read port subtracts; this block drives rd_addr = idx + RD_ADDR_OFS
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  p0_req        in   1       port 0 request; hold with fields stable until p0_ack
//  p0_we         in   1       1 = write, 0 = read
//  p0_idx        in   7       register index
//  p0_wdata      in   DATA_W  write data
//  p0_ack        out  1       1-cycle pulse: request accepted
//  p0_rsp_valid  out  1       1-cycle pulse: access complete (reads and writes)
//  p0_rsp_data   out  DATA_W  read data; valid with p0_rsp_valid; 0 for writes
//  p1_*          -    -       identical set for port 1
//  mem_wr_en     out  1       storage write enable
//  mem_wr_addr   out  7       storage write address (= idx)
//  mem_wr_data   out  DATA_W  storage write data
//  mem_rd_addr   out  7       storage read address (= idx + RD_ADDR_OFS, mod 128)
//  mem_rd_data   in   DATA_W  storage read data, combinational from mem_rd_addr
//  busy          out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE; last_grant = 1 (port 0 wins the first tie).
//  Registered request fields are cleared.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. One transaction in flight.
//  IDLE: if any req is high, grant = the requester not equal to last_grant when both are high, else the only one.
//    Same cycle: pulse pN_ack; register we/idx/wdata; last_grant <= N; go to ACCESS.
//  ACCESS (1 cycle): write -> mem_wr_en = 1 with addr/data from the registers.
//    Read -> mem_rd_addr driven; mem_rd_data captured into rdata_q at the clock edge. Go to RESP.
//  RESP (1 cycle): pulse pN_rsp_valid and drive pN_rsp_data = rdata_q (0 for a write); go to IDLE.
//  Latency: ack at cycle T, rsp_valid at T+2; the next ack is no earlier than T+3.
//  Peak rate: 1 access per 3 cycles.
//  mem_wr_en is asserted only in ACCESS and only for writes.
//  mem_rd_addr holds its last value outside ACCESS.
//  A request dropped before ack is ignored. A req held high after ack is treated as a new request.
//  Both requesting continuously: grants strictly alternate 0,1,0,1...
//  Index arithmetic: the read-address add is 7-bit, wrapping mod 128.
//  A write followed by a read to the same idx from either port returns the new data (serialised, no bypass needed).
//  Reset mid-transaction: the transaction is abandoned; no rsp_valid; no mem_wr_en in the cycle after rst.
//  While rst is high: no ack and no mem_wr_en.
// CONFIGURATION
//  REGARB_BOUNDS_CHK_EN defined: a request with idx >= NUM_REGS is acked but no storage access is made.
//    rsp_valid still arrives at T+2 with rsp_data = 0 and a 1-cycle pN_rsp_err pulse (extra out port, 1 bit).
//  REGARB_BOUNDS_CHK_EN undefined: no pN_rsp_err ports; idx is passed through unchecked.
// TESTING
//  1 Post-reset idle: all outputs 0, busy 0; one cycle of p0_req on a read -> p0_ack pulses in that cycle.
//  2 p0 write idx 3 = 0xDEADBEEF -> ack@T; mem_wr_en=1, wr_addr 3 @T+1; p0_rsp_valid@T+2 with data 0.
//    Then p1 read idx 3 -> mem_rd_addr 9; p1_rsp_data 0xDEADBEEF.
//  3 p0 and p1 both request continuously for 8 grants -> acks alternate p0,p1,p0,...
//    Each port gets 4 acks; ack spacing is exactly 3 cycles.
//  4 Read idx 5 straight after reset -> rsp_data 0x141 (storage reset value).
//  5 rst asserted in ACCESS of a write -> no rsp_valid; the entry keeps its reset value; next request is served normally.
//  6 REGARB_BOUNDS_CHK_EN defined: p1 write idx 40 -> no mem_wr_en; p1_rsp_err and p1_rsp_valid @T+2.
//    Undefined: the same write drives wr_addr 40.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin sharing of a 1W/1R register-file storage between two requesters; REGARB_BOUNDS_CHK_EN adds index bounds checking and pN_rsp_err
module regfile_access_arbiter #(
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 32,
    parameter int RD_ADDR_OFS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [6:0]        p0_idx,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_data,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [6:0]        p1_idx,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,
`ifdef REGARB_BOUNDS_CHK_EN
    output logic              p0_rsp_err,
    output logic              p1_rsp_err,
`endif
    output logic              mem_wr_en,
    output logic [6:0]        mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [6:0]        mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);
`ifdef REGARB_BOUNDS_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic grant_q, grant_d, last_grant_q, last_grant_d, we_q, we_d;
    logic [6:0] idx_q, idx_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic pick, oob, rd_ok;
    assign mem_wr_addr = idx_q;
    assign mem_wr_data = wdata_q;
    assign mem_rd_addr = rd_addr_d;
    // next-state, arbitration and storage/response strobes; rst silences all strobes
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rd_addr_d    = rd_addr_q;
        rdata_d      = rdata_q;
        p0_ack       = 1'b0;
        p1_ack       = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        p0_rsp_data  = '0;
        p1_rsp_data  = '0;
        mem_wr_en    = 1'b0;
`ifdef REGARB_BOUNDS_CHK_EN
        p0_rsp_err   = 1'b0;
        p1_rsp_err   = 1'b0;
`endif
        pick  = (p0_req && p1_req) ? !last_grant_q : p1_req;
        oob   = CHK_EN && (int'({25'd0, idx_q}) >= NUM_REGS);
        rd_ok = !we_q && !oob;
        case (state_q)
            IDLE: if (p0_req || p1_req) begin
                p0_ack       = !pick;
                p1_ack       = pick;
                grant_d      = pick;
                last_grant_d = pick;
                we_d         = pick ? p1_we : p0_we;
                idx_d        = pick ? p1_idx : p0_idx;
                wdata_d      = pick ? p1_wdata : p0_wdata;
                state_d      = ACCESS;
            end
            ACCESS: begin
                mem_wr_en = we_q && !oob;
                rd_addr_d = rd_ok ? idx_q + 7'(RD_ADDR_OFS) : rd_addr_q;
                rdata_d   = rd_ok ? mem_rd_data : '0;
                state_d   = RESP;
            end
            RESP: begin
                p0_rsp_valid = !grant_q;
                p1_rsp_valid = grant_q;
                p0_rsp_data  = grant_q ? '0 : rdata_q;
                p1_rsp_data  = grant_q ? rdata_q : '0;
`ifdef REGARB_BOUNDS_CHK_EN
                p0_rsp_err   = !grant_q && oob;
                p1_rsp_err   = grant_q && oob;
`endif
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy = !rst && (state_q != IDLE);
        if (rst) begin
            p0_ack       = 1'b0;
            p1_ack       = 1'b0;
            p0_rsp_valid = 1'b0;
            p1_rsp_valid = 1'b0;
            p0_rsp_data  = '0;
            p1_rsp_data  = '0;
            mem_wr_en    = 1'b0;
`ifdef REGARB_BOUNDS_CHK_EN
            p0_rsp_err   = 1'b0;
            p1_rsp_err   = 1'b0;
`endif
        end
    end
    // state and registered request fields; port 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rd_addr_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rd_addr_q    <= rd_addr_d;
            rdata_q      <= rdata_d;
        end
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: randomized scoreboard bench for regfile_access_arbiter with a storage model
module tb_regfile_access_arbiter;
`ifdef REGARB_BOUNDS_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [6:0] p0_idx = '0, p1_idx = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic p0_ack, p0_rsp_valid, p1_ack, p1_rsp_valid, mem_wr_en, busy;
    logic [31:0] p0_rsp_data, p1_rsp_data, mem_wr_data, mem_rd_data;
    logic [6:0] mem_wr_addr, mem_rd_addr;
`ifdef REGARB_BOUNDS_CHK_EN
    logic p0_rsp_err, p1_rsp_err;
`endif
    regfile_access_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_idx(p0_idx), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req(p1_req), .p1_we(p1_we), .p1_idx(p1_idx), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
`ifdef REGARB_BOUNDS_CHK_EN
        .p0_rsp_err(p0_rsp_err), .p1_rsp_err(p1_rsp_err),
`endif
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .busy(busy)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        int          cyc;
        bit          port;
        bit          we;
        logic [6:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] sto [128];
    int ack_cnt [2];
    bit got [2];
    int last_ack = -100;
    bit last_grant = 1'b1;
    function automatic logic [31:0] init_val(int i);
        return 32'(i * 64 + 1);
    endfunction
    function automatic logic [31:0] ref_val(int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_val(i);
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    // storage: read port subtracts the offset, 7-bit wrap
    assign mem_rd_data = sto[mem_rd_addr - 7'd6];
    initial begin
        for (int i = 0; i < 128; i++) sto[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en) sto[mem_wr_addr] <= mem_wr_data;
        end
    end
    // reference arbiter: an IDLE slot opens 3 cycles after the previous grant; round-robin on ties
    task automatic model_ack();
        bit exp_ack, port;
        exp_t e;
        got[0] = 1'b0;
        got[1] = 1'b0;
        if (rst) begin
            if (p0_req || p1_req) chk("ack_in_rst", {30'd0, p1_ack, p0_ack}, 0);
            last_grant = 1'b1;
            last_ack = -100;
            q.delete();
        end else begin
            exp_ack = (p0_req || p1_req) && cyc >= last_ack + 3;
            port = (p0_req && p1_req) ? !last_grant : p1_req;
            if (exp_ack || p0_ack || p1_ack)
                chk("ack", {30'd0, p1_ack, p0_ack}, exp_ack ? (port ? 2 : 1) : 0);
            if (exp_ack) begin
                e.cyc = cyc;
                e.port = port;
                e.we = port ? p1_we : p0_we;
                e.idx = port ? p1_idx : p0_idx;
                e.wdata = port ? p1_wdata : p0_wdata;
                e.err = CHK_EN && e.idx >= 7'd32;
                e.rdata = ref_val(int'(e.idx));
                q.push_back(e);
                last_ack = cyc;
                last_grant = port;
                ack_cnt[port]++;
                got[port] = 1'b1;
            end
        end
    endtask
    task automatic step();
        @(negedge clk);
        model_ack();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(int p, bit r, bit we, logic [6:0] idx, logic [31:0] wd);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_idx = idx; p0_wdata = wd;
        end else begin
            p1_req = r; p1_we = we; p1_idx = idx; p1_wdata = wd;
        end
    endtask
    task automatic rnd_drive(int p, bit r);
        logic [6:0] idx;
        idx = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 31));
        drive(p, r, 1'($urandom_range(0, 1)), idx, $urandom);
    endtask
    task automatic req_one(int p, bit we, logic [6:0] idx, logic [31:0] wd);
        drive(p, 1'b1, we, idx, wd);
        for (int i = 0; i < 20; i++) begin
            step();
            if (got[p]) break;
        end
        if (!got[p]) begin
            errors++;
            $display("FAIL ack_timeout: port %0d got no grant within 20 cycles", p);
        end
        drive(p, 1'b0, we, idx, wd);
    endtask
    // monitor: pops the scoreboard and checks storage strobes, busy and responses
    initial begin : mon
        exp_t h;
        bit hv, acc, rsp, wexp;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_quiet", {29'd0, mem_wr_en, p1_rsp_valid, p0_rsp_valid}, 0);
            end else begin
                hv = q.size() > 0;
                if (hv) h = q[0];
                acc = hv && cyc == h.cyc + 1;
                rsp = hv && cyc == h.cyc + 2;
                wexp = acc && h.we && !h.err;
                if (wexp || mem_wr_en) chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, wexp});
                if (wexp) begin
                    chk("mem_wr_addr", {25'd0, mem_wr_addr}, {25'd0, h.idx});
                    chk("mem_wr_data", mem_wr_data, h.wdata);
                end
                if (acc && !h.we && !h.err) chk("mem_rd_addr", {25'd0, mem_rd_addr}, {25'd0, 7'(h.idx + 7'd6)});
                chk("busy", {31'd0, busy}, {31'd0, acc || rsp});
                if (rsp || p0_rsp_valid || p1_rsp_valid)
                    chk("rsp_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, rsp ? (h.port ? 2 : 1) : 0);
                if (rsp) begin
                    chk("rsp_data", h.port ? p1_rsp_data : p0_rsp_data, (h.we || h.err) ? 32'd0 : h.rdata);
`ifdef REGARB_BOUNDS_CHK_EN
                    chk("rsp_err", {30'd0, p1_rsp_err, p0_rsp_err}, h.err ? (h.port ? 2 : 1) : 0);
`endif
                    if (h.we && !h.err) ref_mem[int'(h.idx)] = h.wdata;
                    void'(q.pop_front());
                end
            end
        end
    end
    initial begin
        int a0, a1;
        drive(0, 1'b1, 1'b0, 7'd5, 32'd0);
        step();
        step();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
        @(negedge clk);
        chk("post_rst_ctl", {12'd0, p0_ack, p1_ack, p0_rsp_valid, p1_rsp_valid, mem_wr_en, busy, mem_wr_addr, mem_rd_addr}, 0);
        chk("post_rst_data", p0_rsp_data | p1_rsp_data | mem_wr_data, 0);
`ifdef REGARB_BOUNDS_CHK_EN
        chk("post_rst_err", {30'd0, p0_rsp_err, p1_rsp_err}, 0);
`endif
        @(posedge clk);
        #1;
        req_one(0, 1'b0, 7'd5, 32'd0);
        req_one(0, 1'b1, 7'd3, 32'hDEADBEEF);
        repeat (2) step();
        req_one(1, 1'b0, 7'd3, 32'd0);
        req_one(1, 1'b0, 7'd127, 32'd0);
        req_one(0, 1'b1, 7'd31, 32'h31313131);
        req_one(1, 1'b0, 7'd31, 32'd0);
        req_one(0, 1'b0, 7'd32, 32'd0);
        req_one(1, 1'b1, 7'd40, 32'h12345678);
        req_one(0, 1'b0, 7'd40, 32'd0);
        repeat (3) step();
        req_one(0, 1'b1, 7'd7, 32'hCAFEF00D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        req_one(1, 1'b0, 7'd7, 32'd0);
        repeat (3) step();
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        rnd_drive(0, 1'b1);
        rnd_drive(1, 1'b1);
        for (int i = 0; i < 40 && (ack_cnt[0] - a0) + (ack_cnt[1] - a1) < 8; i++) begin
            step();
            for (int p = 0; p < 2; p++) if (got[p]) rnd_drive(p, 1'b1);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("p0_grants", 32'(ack_cnt[0] - a0), 4);
        chk("p1_grants", 32'(ack_cnt[1] - a1), 4);
        repeat (400) begin
            step();
            for (int p = 0; p < 2; p++)
                if (got[p]) rnd_drive(p, 1'($urandom_range(0, 1)));
                else if (!(p == 1 ? p1_req : p0_req) && $urandom_range(0, 2) == 0) rnd_drive(p, 1'b1);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
